// File: rtl/dmem_if.sv
// dmem_if: data-memory bus between the dcache controller (master) and the memory responder (slave)
interface dmem_if;
  logic [1:0]  proc2mem_command;
  logic [15:0] proc2mem_addr;
  logic [1:0]  proc2mem_size;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;
  modport master (
    output proc2mem_command, proc2mem_addr, proc2mem_size, proc2mem_data,
    input  mem2proc_response, mem2proc_data, mem2proc_tag
  );
  modport slave (
    input  proc2mem_command, proc2mem_addr, proc2mem_size, proc2mem_data,
    output mem2proc_response, mem2proc_data, mem2proc_tag
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: 64-bit data memory answering loads with tagged data LATENCY cycles later; DMEM_STALL_EN refuses every eighth cycle
module dmem_responder #(
  parameter int LATENCY   = 4,
  parameter int MEM_WORDS = 1024
) (
  input logic   clock,
  input logic   reset,
  dmem_if.slave bus
);
  localparam int IW = $clog2(MEM_WORDS);
  logic [63:0] mem [MEM_WORDS];
  logic [3:0] next_tag;
  logic [LATENCY-1:0] pv;
  logic [LATENCY-1:0][3:0] pt;
  logic [LATENCY-1:0][63:0] pd;
  logic stall, is_ld, is_st;
  logic [IW-1:0] idx;
  logic [2:0] off;
  logic [7:0] be;
  logic [63:0] wd;
  logic unused_addr;
  assign unused_addr = ^bus.proc2mem_addr;
`ifdef DMEM_STALL_EN
  logic [2:0] stall_cnt;
  // free-running phase counter; the bus is refused whenever it reads 7
  always_ff @(posedge clock or posedge reset)
    if (reset) stall_cnt <= '0;
    else stall_cnt <= stall_cnt + 3'd1;
  assign stall = &stall_cnt;
`else
  assign stall = 1'b0;
`endif
  assign is_ld = bus.proc2mem_command == 2'd1 && !stall;
  assign is_st = bus.proc2mem_command == 2'd2 && !stall;
  assign idx = bus.proc2mem_addr[3 +: IW];
  assign off = bus.proc2mem_addr[2:0];
  assign bus.mem2proc_response = (is_ld || is_st) ? next_tag : 4'd0;
  assign bus.mem2proc_tag = pv[LATENCY-1] ? pt[LATENCY-1] : 4'd0;
  assign bus.mem2proc_data = pv[LATENCY-1] ? pd[LATENCY-1] : 64'd0;
  // byte enables aligned down to the access size, data replicated across every lane slot
  always_comb begin
    be = bus.proc2mem_size == 2'd0 ? 8'h01 << off :
         bus.proc2mem_size == 2'd1 ? 8'h03 << {off[2:1], 1'b0} :
         bus.proc2mem_size == 2'd2 ? 8'h0f << {off[2], 2'b00} : 8'hff;
    wd = bus.proc2mem_size == 2'd0 ? {8{bus.proc2mem_data[7:0]}} :
         bus.proc2mem_size == 2'd1 ? {4{bus.proc2mem_data[15:0]}} :
         bus.proc2mem_size == 2'd2 ? {2{bus.proc2mem_data[31:0]}} : bus.proc2mem_data;
  end
  // store commit; array contents survive reset
  always_ff @(posedge clock)
    if (is_st)
      for (int i = 0; i < 8; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  // tag allocation and the fixed-latency return pipeline
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      next_tag <= 4'd1;
      pv <= '0;
      pt <= '0;
      pd <= '0;
    end else begin
      if (is_ld) next_tag <= next_tag == 4'd15 ? 4'd1 : next_tag + 4'd1;
      pv[0] <= is_ld;
      pt[0] <= next_tag;
      pd[0] <= mem[idx];
      for (int i = 1; i < LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pt[i] <= pt[i-1];
        pd[i] <= pd[i-1];
      end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: random and directed bus traffic scored against a byte-level memory model
module tb_dmem_responder;
  localparam int LATENCY = 4;
  localparam int MEM_WORDS = 1024;
  typedef struct {
    int          due;
    logic [3:0]  tag;
    logic [63:0] data;
  } ret_t;
  logic clock, reset;
  int cyc, rel_cyc, checks, errors, mtag;
  logic [7:0] mb [72];
  logic [3:0] resp_q [$];
  ret_t ret_q [$];
  ret_t mon_r;
  logic [3:0] mon_e;
  dmem_if bus ();
  dmem_responder #(.LATENCY(LATENCY), .MEM_WORDS(MEM_WORDS)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", n, a, e, cyc);
    end
  endtask
  function automatic bit stall_at(input int k);
`ifdef DMEM_STALL_EN
    return ((k - rel_cyc) % 8) == 7;
`else
    return (k < 0);
`endif
  endfunction
  function automatic logic [15:0] mk(input int w);
    logic [2:0] hi, lo;
    logic [3:0] wi;
    hi = 3'($urandom);
    lo = 3'($urandom);
    wi = 4'(w);
    return {hi, 6'b0, wi, lo};
  endfunction
  task automatic step(input logic [1:0] c, input logic [15:0] a, input logic [1:0] s, input logic [63:0] d);
    bit acc;
    int ba, n, base;
    ret_t r;
    @(posedge clock);
    #1;
    bus.proc2mem_command = c;
    bus.proc2mem_addr = a;
    bus.proc2mem_size = s;
    bus.proc2mem_data = d;
    acc = (c == 2'd1 || c == 2'd2) && !stall_at(cyc);
    resp_q.push_back(acc ? 4'(mtag) : 4'd0);
    ba = int'(a) & (MEM_WORDS * 8 - 1);
    if (acc && c == 2'd2) begin
      n = 1 << s;
      base = ba & ~(n - 1);
      for (int k = 0; k < n; k++) mb[base + k] = d[8*k +: 8];
    end
    if (acc && c == 2'd1) begin
      base = ba & ~7;
      for (int k = 0; k < 8; k++) r.data[8*k +: 8] = mb[base + k];
      r.due = cyc + LATENCY;
      r.tag = 4'(mtag);
      ret_q.push_back(r);
      mtag = mtag == 15 ? 1 : mtag + 1;
    end
  endtask
  task automatic sure(input logic [1:0] c, input logic [15:0] a, input logic [1:0] s, input logic [63:0] d);
    if (stall_at(cyc + 1)) step(2'd0, 16'd0, 2'd0, 64'd0);
    step(c, a, s, d);
  endtask
  always @(negedge clock) begin
    if (resp_q.size() != 0) begin
      mon_e = resp_q.pop_front();
      check("response", 64'(bus.mem2proc_response), 64'(mon_e));
    end
    if (ret_q.size() != 0 && ret_q[0].due == cyc) begin
      mon_r = ret_q.pop_front();
      check("return_tag", 64'(bus.mem2proc_tag), 64'(mon_r.tag));
      check("return_data", bus.mem2proc_data, mon_r.data);
    end else begin
      check("idle_tag", 64'(bus.mem2proc_tag), 64'd0);
      check("idle_data", bus.mem2proc_data, 64'd0);
    end
  end
  initial begin
    clock = 0;
    reset = 1;
    cyc = 0;
    rel_cyc = 0;
    checks = 0;
    errors = 0;
    mtag = 1;
    bus.proc2mem_command = 2'd0;
    bus.proc2mem_addr = 16'd0;
    bus.proc2mem_size = 2'd0;
    bus.proc2mem_data = 64'd0;
    repeat (3) @(posedge clock);
    #1;
    reset = 0;
    rel_cyc = cyc;
    for (int w = 0; w < 9; w++) sure(2'd2, 16'(w << 3), 2'd3, {$urandom, $urandom});
    sure(2'd2, 16'h0040, 2'd3, 64'h1122334455667788);
    sure(2'd1, 16'h0040, 2'd0, 64'd0);
    sure(2'd2, 16'h0043, 2'd0, 64'h00000000000000AB);
    sure(2'd1, 16'h0040, 2'd0, 64'd0);
    sure(2'd2, 16'h0046, 2'd1, 64'h000000000000BEEF);
    sure(2'd1, 16'h0040, 2'd0, 64'd0);
    for (int i = 0; i < 16; i++) step(2'd1, mk($urandom % 9), 2'd0, 64'd0);
    for (int i = 0; i < 20; i++)
      step($urandom % 2 ? 2'd3 : 2'd0, 16'($urandom), 2'($urandom), {$urandom, $urandom});
    for (int i = 0; i < 400; i++)
      step(2'($urandom), mk($urandom % 9), 2'($urandom), {$urandom, $urandom});
    sure(2'd1, mk($urandom % 9), 2'd0, 64'd0);
    sure(2'd1, mk($urandom % 9), 2'd0, 64'd0);
    step(2'd0, 16'd0, 2'd0, 64'd0);
    while (ret_q.size() != 0 && ret_q[0].due > cyc + 1) step(2'd0, 16'd0, 2'd0, 64'd0);
    @(posedge clock);
    #1;
    resp_q.push_back(4'd0);
    if (ret_q.size() != 0) check("pre_reset_tag", 64'(bus.mem2proc_tag), 64'(ret_q[0].tag));
    reset = 1;
    ret_q.delete();
    mtag = 1;
    #1;
    check("reset_tag", 64'(bus.mem2proc_tag), 64'd0);
    check("reset_data", bus.mem2proc_data, 64'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 0;
    rel_cyc = cyc;
    sure(2'd1, mk($urandom % 9), 2'd0, 64'd0);
    for (int i = 0; i < 100; i++)
      step(2'($urandom), mk($urandom % 9), 2'($urandom), {$urandom, $urandom});
    for (int w = 0; w < 9; w++) sure(2'd1, mk(w), 2'd0, 64'd0);
    step(2'd0, 16'd0, 2'd0, 64'd0);
    for (int i = 0; i < 30 && ret_q.size() != 0; i++) step(2'd0, 16'd0, 2'd0, 64'd0);
    if (ret_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d returns outstanding, expected 0", ret_q.size());
    end
    step(2'd0, 16'd0, 2'd0, 64'd0);
    @(posedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
